// File: rtl/em_weight_loader.sv
// Write-side loader for the Ising macro: streams J rows out as one-hot WWL pulses with
// programmable high/low timing, then latches the h bias vector and the scaling factor.
module em_weight_loader #(
   parameter int unsigned NUM_SPIN         = 256,
   parameter int unsigned BITJ             = 4,
   parameter int unsigned BITH             = 4,
   parameter int unsigned SCALING_BIT      = 5,
   parameter int unsigned COUNTER_BITWIDTH = 16,
   parameter int unsigned LITTLE_ENDIAN    = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_i,
   input  logic [COUNTER_BITWIDTH-1:0]   cfg_wwl_high_i,
   input  logic [COUNTER_BITWIDTH-1:0]   cfg_wwl_low_i,
   input  logic [COUNTER_BITWIDTH-1:0]   cfg_row_last_i,
   input  logic                          row_valid_i,
   output logic                          row_ready_o,
   input  logic [NUM_SPIN*BITJ-1:0]      row_data_i,
   input  logic                          hs_valid_i,
   output logic                          hs_ready_o,
   input  logic [NUM_SPIN*BITH-1:0]      hbias_i,
   input  logic [SCALING_BIT-1:0]        scaling_i,
   output logic [NUM_SPIN-1:0]           wwl_o,
   output logic [NUM_SPIN*BITJ-1:0]      wbl_o,
   output logic [NUM_SPIN*BITH-1:0]      hbias_o,
   output logic [SCALING_BIT-1:0]        scaling_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int unsigned IdxW = (NUM_SPIN > 1) ? $clog2(NUM_SPIN) : 1;
   localparam logic [COUNTER_BITWIDTH-1:0] RowMax = COUNTER_BITWIDTH'(NUM_SPIN - 1);
   localparam logic [COUNTER_BITWIDTH-1:0] One    = COUNTER_BITWIDTH'(1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StWaitRow = 3'd1;
   localparam logic [2:0] StHigh    = 3'd2;
   localparam logic [2:0] StLow     = 3'd3;
   localparam logic [2:0] StWaitH   = 3'd4;
   localparam logic [2:0] StDone    = 3'd5;

   logic [2:0]                  state_q, state_d;
   logic [COUNTER_BITWIDTH-1:0] cnt_q, cnt_d;
   logic [COUNTER_BITWIDTH-1:0] row_idx_q, row_idx_d;
   logic [COUNTER_BITWIDTH-1:0] high_q, high_d;
   logic [COUNTER_BITWIDTH-1:0] low_q, low_d;
   logic [COUNTER_BITWIDTH-1:0] last_q, last_d;
   logic [NUM_SPIN*BITJ-1:0]    wbl_q, wbl_d;
   logic [NUM_SPIN*BITH-1:0]    hbias_q, hbias_d;
   logic [SCALING_BIT-1:0]      scaling_q, scaling_d;
   logic [NUM_SPIN-1:0]         wwl_q, wwl_d;
   logic                        row_ready_q, row_ready_d;
   logic                        hs_ready_q, hs_ready_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;

   logic [IdxW-1:0]             row_lsb, wwl_sel;
   logic [NUM_SPIN-1:0]         wwl_onehot;

   // Big-endian mode drives row 0 onto the top word-line.
   assign row_lsb = row_idx_q[IdxW-1:0];
   assign wwl_sel = (LITTLE_ENDIAN != 0) ? row_lsb : IdxW'(NUM_SPIN - 1) - row_lsb;

   always_comb begin
      wwl_onehot          = '0;
      wwl_onehot[wwl_sel] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_idx_d = row_idx_q;
      high_d    = high_q;
      low_d     = low_q;
      last_d    = last_q;
      wbl_d     = wbl_q;
      hbias_d   = hbias_q;
      scaling_d = scaling_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               high_d    = (cfg_wwl_high_i == '0) ? One : cfg_wwl_high_i;
               low_d     = (cfg_wwl_low_i == '0) ? One : cfg_wwl_low_i;
               last_d    = (cfg_row_last_i > RowMax) ? RowMax : cfg_row_last_i;
               row_idx_d = '0;
               state_d   = StWaitRow;
            end
         end
         StWaitRow: begin
            if (row_valid_i && row_ready_q) begin
               wbl_d   = row_data_i;
               cnt_d   = high_q;
               state_d = StHigh;
            end
         end
         StHigh: begin
            if (cnt_q <= One) begin
               cnt_d   = low_q;
               state_d = StLow;
            end else begin
               cnt_d = cnt_q - One;
            end
         end
         StLow: begin
            if (cnt_q <= One) begin
               if (row_idx_q == last_q) begin
                  state_d = StWaitH;
               end else begin
                  row_idx_d = row_idx_q + One;
                  state_d   = StWaitRow;
               end
            end else begin
               cnt_d = cnt_q - One;
            end
         end
         StWaitH: begin
            if (hs_valid_i && hs_ready_q) begin
               hbias_d   = hbias_i;
               scaling_d = scaling_i;
               state_d   = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   assign wwl_d       = (state_d == StHigh) ? wwl_onehot : '0;
   assign row_ready_d = (state_d == StWaitRow);
   assign hs_ready_d  = (state_d == StWaitH);
   assign busy_d      = (state_d != StIdle);
   assign done_d      = (state_d == StDone);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         row_idx_q   <= '0;
         high_q      <= '0;
         low_q       <= '0;
         last_q      <= '0;
         wbl_q       <= '0;
         hbias_q     <= '0;
         scaling_q   <= '0;
         wwl_q       <= '0;
         row_ready_q <= 1'b0;
         hs_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_idx_q   <= row_idx_d;
         high_q      <= high_d;
         low_q       <= low_d;
         last_q      <= last_d;
         wbl_q       <= wbl_d;
         hbias_q     <= hbias_d;
         scaling_q   <= scaling_d;
         wwl_q       <= wwl_d;
         row_ready_q <= row_ready_d;
         hs_ready_q  <= hs_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign wwl_o       = wwl_q;
   assign wbl_o       = wbl_q;
   assign hbias_o     = hbias_q;
   assign scaling_o   = scaling_q;
   assign row_ready_o = row_ready_q;
   assign hs_ready_o  = hs_ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

`ifndef SYNTHESIS
   wwl_onehot0_a: assert property (@(posedge clk_i) $onehot0(wwl_o));
`endif

endmodule

// File: tb/tb_em_weight_loader.sv
// Directed bench for em_weight_loader: a table of load scenarios run on a big- and a
// little-endian instance in parallel, plus reset checks and an aborted load.
module tb_em_weight_loader;

   localparam int unsigned NS = 4;
   localparam int unsigned BJ = 4;
   localparam int unsigned BH = 4;
   localparam int unsigned SB = 5;
   localparam int unsigned CW = 16;

   logic                clk;
   logic                rst_n;
   logic                start_i;
   logic [CW-1:0]       cfg_wwl_high_i, cfg_wwl_low_i, cfg_row_last_i;
   logic                row_valid_i;
   logic [NS*BJ-1:0]    row_data_i;
   logic                hs_valid_i;
   logic [NS*BH-1:0]    hbias_i;
   logic [SB-1:0]       scaling_i;

   logic                row_ready_be, hs_ready_be, busy_be, done_be;
   logic [NS-1:0]       wwl_be;
   logic [NS*BJ-1:0]    wbl_be;
   logic [NS*BH-1:0]    hbias_be;
   logic [SB-1:0]       scaling_be;
   logic                row_ready_le, hs_ready_le, busy_le, done_le;
   logic [NS-1:0]       wwl_le;
   logic [NS*BJ-1:0]    wbl_le;
   logic [NS*BH-1:0]    hbias_le;
   logic [SB-1:0]       scaling_le;

   em_weight_loader #(
      .NUM_SPIN(NS), .BITJ(BJ), .BITH(BH), .SCALING_BIT(SB), .COUNTER_BITWIDTH(CW),
      .LITTLE_ENDIAN(0)
   ) u_dut_be (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_i),
      .cfg_wwl_high_i(cfg_wwl_high_i), .cfg_wwl_low_i(cfg_wwl_low_i),
      .cfg_row_last_i(cfg_row_last_i),
      .row_valid_i(row_valid_i), .row_ready_o(row_ready_be), .row_data_i(row_data_i),
      .hs_valid_i(hs_valid_i), .hs_ready_o(hs_ready_be), .hbias_i(hbias_i),
      .scaling_i(scaling_i), .wwl_o(wwl_be), .wbl_o(wbl_be), .hbias_o(hbias_be),
      .scaling_o(scaling_be), .busy_o(busy_be), .done_o(done_be)
   );

   em_weight_loader #(
      .NUM_SPIN(NS), .BITJ(BJ), .BITH(BH), .SCALING_BIT(SB), .COUNTER_BITWIDTH(CW),
      .LITTLE_ENDIAN(1)
   ) u_dut_le (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_i),
      .cfg_wwl_high_i(cfg_wwl_high_i), .cfg_wwl_low_i(cfg_wwl_low_i),
      .cfg_row_last_i(cfg_row_last_i),
      .row_valid_i(row_valid_i), .row_ready_o(row_ready_le), .row_data_i(row_data_i),
      .hs_valid_i(hs_valid_i), .hs_ready_o(hs_ready_le), .hbias_i(hbias_i),
      .scaling_i(scaling_i), .wwl_o(wwl_le), .wbl_o(wbl_le), .hbias_o(hbias_le),
      .scaling_o(scaling_le), .busy_o(busy_le), .done_o(done_le)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] last, hi, lo;
      int            stall_row, stall_len;
      bit            poke, early_hs;
      logic [15:0]   hbias;
      logic [4:0]    scal;
      int            exp_rows, exp_hi, exp_lo, exp_done;
   } vec_t;

   vec_t vecs[5];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string what, input int vi, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (vec %0d): got %0h, want %0h", what, vi, act, exp);
      end
   endtask

   function automatic logic [15:0] row_word(input int k);
      return 16'(32'h1111 * (k + 1));
   endfunction

   // Row k lights bit k (little-endian) or bit NS-1-k (big-endian).
   function automatic logic [3:0] wwl_exp(input int k, input bit le);
      logic [3:0] one;
      one = 4'b0001;
      if (le) return one << k;
      return one << (3 - k);
   endfunction

   task automatic idle_inputs();
      start_i        = 1'b0;
      row_valid_i    = 1'b0;
      hs_valid_i     = 1'b0;
      row_data_i     = '0;
      hbias_i        = '0;
      scaling_i      = '0;
      cfg_wwl_high_i = '0;
      cfg_wwl_low_i  = '0;
      cfg_row_last_i = '0;
   endtask

   task automatic run_load(input vec_t v, input int vi);
      int n, acc, h_acc, pulses, hi_run, lo_run, stalled;
      bit in_low, poked, hsr, hsh, seen_done;
      n = 0; acc = 0; h_acc = 0; pulses = 0; hi_run = 0; lo_run = 0; stalled = 0;
      in_low = 1'b0; poked = 1'b0; seen_done = 1'b0;
      cfg_wwl_high_i = v.hi;
      cfg_wwl_low_i  = v.lo;
      cfg_row_last_i = v.last;
      row_valid_i    = 1'b1;
      row_data_i     = row_word(0);
      hs_valid_i     = v.early_hs;
      hbias_i        = v.hbias;
      scaling_i      = v.scal;
      start_i        = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      while (!seen_done && n < 300) begin
         if (acc < 10) begin
            row_data_i = row_word(acc);
            if (acc == v.stall_row && stalled < v.stall_len) begin
               row_valid_i = 1'b0;
               if (row_ready_be) stalled++;
            end else begin
               row_valid_i = 1'b1;
            end
         end else begin
            row_valid_i = 1'b0;
         end
         if (v.early_hs) hs_valid_i = (h_acc == 0);
         else hs_valid_i = (h_acc == 0) && hs_ready_be;
         hsr = row_valid_i && row_ready_be;
         hsh = hs_valid_i && hs_ready_be;
         if (hsh) begin
            chk("h_beat_after_rows", vi, acc, v.exp_rows);
            chk("h_beat_after_pulses", vi, pulses, v.exp_rows);
         end
         @(posedge clk);
         #1;
         n++;
         start_i = 1'b0;
         if (hsr) acc++;
         if (hsh) h_acc++;
         chk("busy", vi, 32'({busy_be, busy_le}), 32'h3);
         if (row_ready_be) chk("wwl_zero_while_waiting", vi, 32'(wwl_be), 32'h0);
         if (wwl_be != '0) begin
            hi_run++;
            chk("wwl_be", vi, 32'(wwl_be), 32'(wwl_exp(acc - 1, 1'b0)));
            chk("wwl_le", vi, 32'(wwl_le), 32'(wwl_exp(acc - 1, 1'b1)));
            chk("wbl", vi, 32'(wbl_be), 32'(row_word(acc - 1)));
            if (v.poke && !poked) begin
               poked          = 1'b1;
               start_i        = 1'b1;
               cfg_wwl_high_i = 16'd5;
               cfg_row_last_i = 16'd0;
            end
         end else begin
            if (hi_run != 0) begin
               chk("wwl_high_len", vi, hi_run, v.exp_hi);
               hi_run = 0;
               pulses++;
               lo_run = 0;
               in_low = 1'b1;
            end
            if (in_low) begin
               if (row_ready_be || hs_ready_be) begin
                  chk("wwl_low_len", vi, lo_run, v.exp_lo);
                  in_low = 1'b0;
               end else begin
                  lo_run++;
                  chk("wbl_hold_in_low", vi, 32'(wbl_be), 32'(row_word(acc - 1)));
               end
            end
         end
         if (done_be) begin
            seen_done = 1'b1;
            chk("done_cycle", vi, n, v.exp_done);
            chk("done_le", vi, 32'(done_le), 32'h1);
            chk("hbias", vi, 32'(hbias_be), 32'(v.hbias));
            chk("scaling", vi, 32'(scaling_be), 32'(v.scal));
            chk("hbias_le", vi, 32'({scaling_le, hbias_le}), 32'({v.scal, v.hbias}));
         end
      end
      if (!seen_done) chk("done_timeout", vi, 0, 1);
      row_valid_i = 1'b0;
      hs_valid_i  = 1'b0;
      @(posedge clk);
      #1;
      chk("done_single_pulse", vi, 32'(done_be), 32'h0);
      chk("idle_after_done", vi, 32'(busy_be), 32'h0);
      chk("rows_accepted", vi, acc, v.exp_rows);
      chk("pulse_count", vi, pulses, v.exp_rows);
      chk("h_beats", vi, h_acc, 1);
      chk("wbl_retains_last", vi, 32'(wbl_be), 32'(row_word(v.exp_rows - 1)));
      chk("wbl_le_retains_last", vi, 32'(wbl_le), 32'(row_word(v.exp_rows - 1)));
      chk("hbias_held", vi, 32'(hbias_be), 32'(v.hbias));
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      // done cycle = (rows)*(1+high+low) + 1 h beat (+ stall cycles), counted in edges
      // after the start edge.
      vecs[0] = '{16'd3, 16'd2, 16'd2, -1, 0, 1'b0, 1'b0, 16'hABCD, 5'd5,  4, 2, 2, 21};
      vecs[1] = '{16'd3, 16'd0, 16'd0,  2, 3, 1'b0, 1'b0, 16'h1234, 5'd17, 4, 1, 1, 16};
      vecs[2] = '{16'd9, 16'd1, 16'd1, -1, 0, 1'b0, 1'b0, 16'h0F0F, 5'd31, 4, 1, 1, 13};
      vecs[3] = '{16'd3, 16'd2, 16'd2, -1, 0, 1'b1, 1'b1, 16'h5A5A, 5'd0,  4, 2, 2, 21};
      vecs[4] = '{16'd0, 16'd3, 16'd1, -1, 0, 1'b0, 1'b0, 16'hFFFF, 5'd1,  1, 3, 1, 6};

      idle_inputs();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wwl", -1, 32'({wwl_be, wwl_le}), 32'h0);
      chk("rst_wbl", -1, 32'(wbl_be), 32'h0);
      chk("rst_hs", -1, 32'({hbias_be, scaling_be}), 32'h0);
      chk("rst_flags", -1, 32'({busy_be, done_be, row_ready_be, hs_ready_be}), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_no_ready", -1, 32'({row_ready_be, hs_ready_be, busy_be}), 32'h0);

      for (int i = 0; i < 5; i++) run_load(vecs[i], i);

      // Abort during the row-1 pulse, then require a clean full load.
      cfg_wwl_high_i = 16'd2;
      cfg_wwl_low_i  = 16'd2;
      cfg_row_last_i = 16'd3;
      row_valid_i    = 1'b1;
      row_data_i     = row_word(0);
      start_i        = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      k = 0;
      while (wwl_be != 4'b0100 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("abort_reached_row1", 5, 32'({wwl_be, wwl_le}), 32'h42);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_wwl_async", 5, 32'({wwl_be, wwl_le}), 32'h0);
      chk("abort_flags", 5, 32'({busy_be, busy_le, row_ready_be, row_ready_le,
                                 hs_ready_le}), 32'h0);
      chk("abort_wbl", 5, 32'(wbl_be), 32'h0);
      #2 rst_n = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      run_load(vecs[0], 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
